// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forward-select encoding, load result code and controller FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } hz_state_t;

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Operand forwarding select for one execute-stage source.
// Memory stage wins over writeback; x0 is never forwarded.
module forward_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output logic [1:0]                fwd
);

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && rd_m != '0 && rd_m == rs_e) begin
      sel = FWD_M;
    end else if (reg_write_w && rd_w != '0 && rd_w == rs_e) begin
      sel = FWD_W;
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_controller.sv
// Hazard/stall controller: forwarding, load-use stall, branch flush,
// memory wait FSM with timeout and a saturating stall-cycle counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [1:0]                ResultSrcE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemAckM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic                      MemErr,
  output logic [CNT_WIDTH-1:0]      StallCount
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  hz_state_t            state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d, wait_inc;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 miss, mem_stall, lw_stall;

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardAE)
  );

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardBE)
  );

  assign miss      = MemReqM && !MemAckM;
  assign mem_stall = miss || (state_q == ERROR);
  assign lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && RdE != '0
                  && (RdE == Rs1D || RdE == Rs2D);

  // A memory stall freezes everything and masks branch flushes.
  assign StallF = mem_stall || lw_stall;
  assign StallD = mem_stall || lw_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign FlushW = mem_stall;
  assign FlushD = !mem_stall && PCSrcE;
  assign FlushE = !mem_stall && (lw_stall || PCSrcE);
  assign MemErr = err_q;
  assign StallCount = cnt_q;

  assign wait_inc = wait_q + WAIT_ONE;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (miss) begin
          wait_d  = WAIT_ONE;
          state_d = (WAIT_ONE == WAIT_MAX) ? ERROR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (MemAckM || !MemReqM) begin
          wait_d  = '0;
          state_d = RUN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_MAX) state_d = ERROR;
        end
      end
      ERROR: ;
      default: state_d = RUN;
    endcase
    err_d = err_q || (state_d == ERROR);
    cnt_d = (StallF && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
